// File: rtl/csr_pkg.sv
// -----------------------------------------------------------------------------
// csr_pkg
// Shared definitions for the CSR LED PWM block: modify-strobe encodings,
// register offsets inside the four-address window, CTRL field positions and
// the read-modify-write helper used by every register.
// -----------------------------------------------------------------------------
package csr_pkg;

    // CSR modify strobe encodings
    typedef enum logic [1:0] {
        MOD_NONE  = 2'b00,
        MOD_WRITE = 2'b01,
        MOD_SET   = 2'b10,
        MOD_CLEAR = 2'b11
    } modify_e;

    // Register offsets from BASE_ADDR
    localparam logic [1:0] OFS_MASK  = 2'd0;
    localparam logic [1:0] OFS_CTRL  = 2'd1;
    localparam logic [1:0] OFS_INDEX = 2'd2;
    localparam logic [1:0] OFS_DUTY  = 2'd3;

    // CTRL bit positions
    localparam int CTRL_PWM_EN_BIT   = 0;
    localparam int CTRL_BLINK_EN_BIT = 1;
    localparam int CTRL_PERIOD_LSB   = 8;
    localparam int CTRL_PERIOD_MSB   = 15;

    // Implemented bits of the fixed-width registers
    localparam logic [31:0] CTRL_IMPL  = 32'h0000_ff03;
    localparam logic [31:0] INDEX_IMPL = 32'h0000_00ff;

    // Apply a CSR modify operation to a current value. The caller masks the
    // result down to the implemented bits of the target register.
    function automatic logic [31:0] apply_modify(input logic [31:0] cur,
                                                 input logic [31:0] wd,
                                                 input logic [1:0]  mod);
        logic [31:0] res;
        res = cur;
        case (mod)
            MOD_WRITE: res = wd;
            MOD_SET:   res = cur | wd;
            MOD_CLEAR: res = cur & ~wd;
            default:   res = cur;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_pwm_timebase.sv
// -----------------------------------------------------------------------------
// csr_pwm_timebase
// Shared timebase for all LED channels: a prescaler producing one tick every
// PRESCALE clocks, the PWM frame counter, the frame_end strobe and the global
// blink phase generator.
//
// Ports:
//   CLOCK_50         clock
//   rstn             synchronous active-low reset
//   blink_period_i   frames per blink half-period (0 = blink phase held on)
//   blink_restart_i  restart blink sequence (counter to 0, phase on)
//   pwm_cnt_o        current position inside the PWM frame
//   frame_end_o      high in the cycle whose edge wraps the frame counter
//   phase_o          blink phase (1 = LEDs allowed on)
// -----------------------------------------------------------------------------
module csr_pwm_timebase #(
    parameter int PRESCALE = 195,
    parameter int PWM_BITS = 8
) (
    input  logic                CLOCK_50,
    input  logic                rstn,
    input  logic [7:0]          blink_period_i,
    input  logic                blink_restart_i,
    output logic [PWM_BITS-1:0] pwm_cnt_o,
    output logic                frame_end_o,
    output logic                phase_o
);

    // A one-bit prescaler is kept for PRESCALE==1; it never leaves zero.
    localparam int             PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]     ps_q, ps_d;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [7:0]          blink_q, blink_d;
    logic                phase_q, phase_d;
    logic                tick;
    logic                frame_end;

    always_comb begin
        tick      = (ps_q == PS_LAST);
        ps_d      = tick ? '0 : ps_q + 1'b1;
        cnt_d     = tick ? cnt_q + 1'b1 : cnt_q;
        frame_end = tick && (cnt_q == '1);

        blink_d = blink_q;
        phase_d = phase_q;
        // A restart or a zero period pins the phase on; otherwise the phase
        // toggles after blink_period_i complete frames.
        if (blink_restart_i || (blink_period_i == 8'd0)) begin
            blink_d = 8'd0;
            phase_d = 1'b1;
        end else if (frame_end) begin
            if (blink_q == (blink_period_i - 8'd1)) begin
                blink_d = 8'd0;
                phase_d = ~phase_q;
            end else begin
                blink_d = blink_q + 8'd1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!rstn) begin
            ps_q    <= '0;
            cnt_q   <= '0;
            blink_q <= 8'd0;
            phase_q <= 1'b1;
        end else begin
            ps_q    <= ps_d;
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
            phase_q <= phase_d;
        end
    end

    assign pwm_cnt_o   = cnt_q;
    assign frame_end_o = frame_end;
    assign phase_o     = phase_q;

endmodule

// File: rtl/csr_led_pwm.sv
// -----------------------------------------------------------------------------
// csr_led_pwm
// CSR-mapped LED driver: CHANNELS outputs with per-channel PWM brightness,
// a global enable mask and an optional global blink. Four registers at
// BASE_ADDR..BASE_ADDR+3: MASK, CTRL, INDEX, DUTY (duty of channel INDEX).
//
// CSR handshake: any cycle whose addr falls in the window is an access. The
// following cycle presents valid=1 with rdata holding the value the register
// had before the access; outside the window valid=0 and rdata=0. The modify
// strobe (write/set/clear) takes effect on the same edge that captures rdata.
//
// Ports:
//   CLOCK_50       clock
//   rstn           synchronous active-low reset
//   read           CSR read strobe (no functional effect)
//   modify         00 none, 01 write, 10 set bits, 11 clear bits
//   wdata          CSR write data
//   addr           CSR address
//   rdata          registered read data, 0 when not selected
//   valid          registered hit flag
//   leds           registered LED drive
//   AVOID_WARNING  OR-reduction of otherwise unused inputs
// -----------------------------------------------------------------------------
module csr_led_pwm
    import csr_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR  = 12'h7c1,
    parameter int          CHANNELS   = 18,
    parameter int          PWM_BITS   = 8,
    parameter int          PRESCALE   = 195,
    parameter logic [31:0] RESET_MASK = 32'h81
) (
    input  logic                CLOCK_50,
    input  logic                rstn,
    input  logic                read,
    input  logic [1:0]          modify,
    input  logic [31:0]         wdata,
    input  logic [11:0]         addr,
    output logic [31:0]         rdata,
    output logic                valid,
    output logic [CHANNELS-1:0] leds,
    output logic                AVOID_WARNING
);

    localparam logic [31:0] MASK_IMPL = {32{1'b1}} >> (32 - CHANNELS);
    localparam logic [31:0] DUTY_IMPL = {32{1'b1}} >> (32 - PWM_BITS);
    localparam logic [7:0]  CH_LIMIT  = 8'(CHANNELS);

    // Register file
    logic [CHANNELS-1:0] mask_q, mask_d;
    logic                pwm_en_q, pwm_en_d;
    logic                blink_en_q, blink_en_d;
    logic [7:0]          period_q, period_d;
    logic [7:0]          index_q, index_d;
    logic [PWM_BITS-1:0] pend_q [CHANNELS];
    logic [PWM_BITS-1:0] act_q  [CHANNELS];

    // Bus outputs and LED drive
    logic [31:0]         rdata_q, rdata_d;
    logic                valid_q, valid_d;
    logic [CHANNELS-1:0] leds_q, leds_d;

    // Decode / modify datapath
    logic [11:0]         ofs_full;
    logic                hit;
    logic [1:0]          ofs;
    logic                idx_ok;
    logic [PWM_BITS-1:0] sel_duty;
    logic [31:0]         cur_val;
    logic [31:0]         impl_bits;
    logic [31:0]         raw_val;
    logic [31:0]         new_val;
    logic                do_mod;
    logic                duty_we;
    logic                blink_restart;

    // Timebase
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                frame_end;
    logic                phase;

    csr_pwm_timebase #(
        .PRESCALE (PRESCALE),
        .PWM_BITS (PWM_BITS)
    ) u_timebase (
        .CLOCK_50        (CLOCK_50),
        .rstn            (rstn),
        .blink_period_i  (period_q),
        .blink_restart_i (blink_restart),
        .pwm_cnt_o       (pwm_cnt),
        .frame_end_o     (frame_end),
        .phase_o         (phase)
    );

    // Address decode: the subtraction wraps, so a single compare covers the
    // four-address window.
    always_comb begin
        ofs_full = addr - BASE_ADDR;
        hit      = (ofs_full < 12'd4);
        ofs      = ofs_full[1:0];
        idx_ok   = (index_q < CH_LIMIT);
    end

    // Pending duty of the channel selected by INDEX; 0 when out of range.
    always_comb begin
        sel_duty = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (index_q == 8'(i)) begin
                sel_duty = pend_q[i];
            end
        end
    end

    // Pre-modify value and implemented-bit mask of the addressed register.
    always_comb begin
        cur_val   = 32'd0;
        impl_bits = 32'd0;
        case (ofs)
            OFS_MASK: begin
                cur_val   = 32'(mask_q);
                impl_bits = MASK_IMPL;
            end
            OFS_CTRL: begin
                cur_val[CTRL_PWM_EN_BIT]                  = pwm_en_q;
                cur_val[CTRL_BLINK_EN_BIT]                = blink_en_q;
                cur_val[CTRL_PERIOD_MSB:CTRL_PERIOD_LSB]  = period_q;
                impl_bits = CTRL_IMPL;
            end
            OFS_INDEX: begin
                cur_val   = 32'(index_q);
                impl_bits = INDEX_IMPL;
            end
            default: begin
                cur_val   = 32'(sel_duty);
                impl_bits = DUTY_IMPL;
            end
        endcase
        raw_val = apply_modify(cur_val, wdata, modify);
        // Masking here makes set/clear touch only implemented bits.
        new_val = raw_val & impl_bits;
    end

    // Next-state for the register file and bus outputs.
    always_comb begin
        do_mod        = hit && (modify != MOD_NONE);
        blink_restart = do_mod && (ofs == OFS_CTRL);
        duty_we       = do_mod && (ofs == OFS_DUTY) && idx_ok;

        mask_d     = mask_q;
        pwm_en_d   = pwm_en_q;
        blink_en_d = blink_en_q;
        period_d   = period_q;
        index_d    = index_q;

        if (do_mod && (ofs == OFS_MASK)) begin
            mask_d = new_val[CHANNELS-1:0];
        end
        if (blink_restart) begin
            pwm_en_d   = new_val[CTRL_PWM_EN_BIT];
            blink_en_d = new_val[CTRL_BLINK_EN_BIT];
            period_d   = new_val[CTRL_PERIOD_MSB:CTRL_PERIOD_LSB];
        end
        if (do_mod && (ofs == OFS_INDEX)) begin
            index_d = new_val[7:0];
        end

        valid_d = hit;
        rdata_d = hit ? cur_val : 32'd0;
    end

    // LED compare: mask, PWM window against the active (shadowed) duty, blink.
    always_comb begin
        leds_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            leds_d[i] = mask_q[i]
                      & (pwm_en_q   ? (pwm_cnt < act_q[i]) : 1'b1)
                      & (blink_en_q ? phase                : 1'b1);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!rstn) begin
            mask_q     <= RESET_MASK[CHANNELS-1:0];
            pwm_en_q   <= 1'b0;
            blink_en_q <= 1'b0;
            period_q   <= 8'd0;
            index_q    <= 8'd0;
            rdata_q    <= 32'd0;
            valid_q    <= 1'b0;
            leds_q     <= '0;
        end else begin
            mask_q     <= mask_d;
            pwm_en_q   <= pwm_en_d;
            blink_en_q <= blink_en_d;
            period_q   <= period_d;
            index_q    <= index_d;
            rdata_q    <= rdata_d;
            valid_q    <= valid_d;
            leds_q     <= leds_d;
        end
    end

    // Active duty reloads only on frame_end; a DUTY write landing on that
    // same edge is not seen until the next frame because active samples the
    // old pending value.
    always_ff @(posedge CLOCK_50) begin
        if (!rstn) begin
            for (int i = 0; i < CHANNELS; i++) begin
                pend_q[i] <= '1;
                act_q[i]  <= '1;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (frame_end) begin
                    act_q[i] <= pend_q[i];
                end
                if (duty_we && (index_q == 8'(i))) begin
                    pend_q[i] <= new_val[PWM_BITS-1:0];
                end
            end
        end
    end

    assign rdata = rdata_q;
    assign valid = valid_q;
    assign leds  = leds_q;

    // Bits of the modify result that no register stores, plus the read strobe.
    assign AVOID_WARNING = read | (|(raw_val & ~impl_bits));

endmodule

// File: doc/csr_led_pwm.md
Name: csr_led_pwm

Overview:
- Successor to the single-register CSR LED block. Drives CHANNELS LEDs with per-channel PWM brightness, a global enable mask and an optional global blink.
- Sits on the pipeline's CSR bus beside the counter and UART blocks.
- Its valid/rdata are ORed into the shared csr_valid/csr_rdata.
- Occupies four consecutive CSR addresses starting at BASE_ADDR.

Parameters:
- BASE_ADDR, 12'h7c1, first CSR address; block decodes BASE_ADDR..BASE_ADDR+3.
- CHANNELS, 18, number of LED outputs (1..32).
- PWM_BITS, 8, duty/frame counter width (2..16); frame = 2^PWM_BITS ticks.
- PRESCALE, 195, CLOCK_50 cycles per PWM tick (>=1). Default gives about 1 kHz frame.
- RESET_MASK, 'h81, enable-mask value after reset.

Ports:
- CLOCK_50  in  1  clock
- rstn  in  1  synchronous active-low reset
- read  in  1  CSR read strobe (unused functionally, folded into AVOID_WARNING)
- modify  in  2  00 none, 01 write, 10 set bits, 11 clear bits
- wdata  in  32  CSR write data
- addr  in  12  CSR address
- rdata  out  32  registered read data, 0 when not selected
- valid  out  1  registered hit flag
- leds  out  CHANNELS  registered LED drive
- AVOID_WARNING  out  1  OR-reduction of otherwise unused inputs

Behaviour:
- CSR map (offset from BASE_ADDR); every register is read-modify-write via modify:
  - +0 MASK[CHANNELS-1:0]: per-channel enable.
  - +1 CTRL: bit0 PWM_EN, bit1 BLINK_EN, bits[15:8] BLINK_PERIOD. Other bits read 0, writes ignored.
  - +2 INDEX[7:0]: channel selector for DUTY.
  - +3 DUTY[PWM_BITS-1:0]: pending duty of channel INDEX. If INDEX>=CHANNELS, reads return 0 and writes are dropped.
- Access timing:
  - Any cycle with addr in BASE_ADDR..BASE_ADDR+3: next cycle valid=1 and rdata = pre-modify value, zero-extended.
  - Otherwise the next cycle has valid=0 and rdata=0.
  - modify is applied at the same clock edge; the new value is visible on a read one cycle later.
- Set/clear act only on implemented bits.
- Timebase:
  - Prescaler counts 0..PRESCALE-1 and emits tick on wrap.
  - pwm_cnt (PWM_BITS) increments on tick and wraps 2^PWM_BITS-1 -> 0. This wrap is frame_end.
- Duty shadowing:
  - Each channel has pending (CSR-visible) and active duty.
  - All active <= pending on the frame_end tick only; no mid-frame glitches.
  - A DUTY write on the same edge as frame_end: the old pending is copied, the new value takes effect at the following frame_end.
- Blink:
  - blink_cnt (8 bit) increments on each frame_end.
  - When blink_cnt==BLINK_PERIOD-1: phase toggles and blink_cnt clears.
  - BLINK_PERIOD==0: phase forced 1 and blink_cnt held 0.
  - Writing CTRL clears blink_cnt and sets phase=1.
- Output, registered every cycle:
  - leds[i] <= MASK[i] & (PWM_EN ? pwm_cnt < active[i] : 1) & (BLINK_EN ? phase : 1).
  - Duty 0 gives always off; duty 2^PWM_BITS-1 gives on (2^PWM_BITS-1)/2^PWM_BITS of the frame.
- Reset (rstn=0 at an edge, any time incl. mid-frame):
  - MASK=RESET_MASK, CTRL=0, INDEX=0.
  - All pending and active duty = 2^PWM_BITS-1.
  - Prescaler, pwm_cnt and blink_cnt = 0; phase=1.
  - valid=0, rdata=0, leds=0.
- First post-reset edge gives leds=RESET_MASK[CHANNELS-1:0], which matches the legacy LED block's reset display.
- Reset overrides any concurrent CSR modify.

Decomposition:
- csr_pkg holds:
  - modify encodings MOD_NONE/MOD_WRITE/MOD_SET/MOD_CLEAR;
  - offsets OFS_MASK=0, OFS_CTRL=1, OFS_INDEX=2, OFS_DUTY=3;
  - CTRL bit positions.
- Sub-module csr_pwm_timebase (PRESCALE, PWM_BITS) contains prescaler, pwm_cnt, frame_end, blink_cnt and phase. Its inputs are blink_period and blink_restart.
- Top keeps the CSR decode, register file, duty arrays and compare.

Test Plan:
- Bench params: CHANNELS=4, PWM_BITS=4, PRESCALE=1, RESET_MASK='h81.
1. Reset, then idle -> leds=4'h1 one cycle after rstn rises. Read +0 gives valid=1, rdata=32'h1 next cycle. Address 12'h7c5 gives valid=0, rdata=0.
2. Write +1=1 (PWM_EN), MASK=4'hF, INDEX=2, DUTY=5 -> after next frame_end, leds[2] high exactly 5 of 16 cycles per frame. Other channels are high 15/16.
3. Write DUTY=3 mid-frame while duty is 5 -> current frame still shows 5 high cycles; the next frame shows 3.
4. INDEX=7, write DUTY=9 -> read +3 gives 0. Set INDEX=0 and read -> 15 (unchanged).
5. MASK=4'h3, modify=10 wdata=4'h4 gives 4'h7; modify=11 wdata=4'h1 gives 4'h6 -> each read-back shows the pre-modify value one cycle after access.
6. CTRL=0x0203 (PWM+blink, period 2) -> leds gated off for 2 frames (32 cycles), on for 2 frames, repeating. Assert rstn=0 mid-blink -> next edge leds=0, CTRL reads 0.
